// File: rtl/data_cache_wt.sv
// Direct-mapped, write-through, one-word-per-line data cache with a stall handshake toward
// the CPU and a registered req/ack handshake toward a multi-cycle backing memory.
module data_cache_wt #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 6,
  parameter int TAG_WIDTH     = ADDRESS_WIDTH - SET_WIDTH - 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     re,
  input  logic                     we,
  input  logic [1:0]               Size,
  input  logic [ADDRESS_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  output logic [DATA_WIDTH-1:0]    ReadData,
  output logic                     Stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  localparam int unsigned SETS = 1 << SET_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state, state_next;

  logic [TAG_WIDTH-1:0]  tag_arr  [SETS];
  logic [DATA_WIDTH-1:0] data_arr [SETS];
  logic [SETS-1:0]       valid;

  logic [SET_WIDTH-1:0]  idx, m_idx;
  logic [TAG_WIDTH-1:0]  tag, m_tag;
  logic                  hit, m_hit;
  logic [DATA_WIDTH-1:0] line, shifted, merged;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;
  logic                  load_hit, start_fill, start_write, wr_done;

  assign idx   = Address[SET_WIDTH+1:2];
  assign tag   = Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign hit   = valid[idx] && (tag_arr[idx] == tag);
  assign line  = data_arr[idx];
  assign m_idx = mem_addr[SET_WIDTH+1:2];
  assign m_tag = mem_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign m_hit = valid[m_idx] && (tag_arr[m_idx] == m_tag);

  // wr_done lets the held store retire for one cycle after its ack instead of re-issuing.
  assign load_hit    = (state == IDLE) && re && !we && hit;
  assign start_fill  = (state == IDLE) && re && !we && !hit;
  assign start_write = (state == IDLE) && we && !wr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_write) begin
          Stall      = 1'b1;
          state_next = WRITE;
        end else if (start_fill) begin
          Stall      = 1'b1;
          state_next = FILL;
        end
      end
      FILL, WRITE: begin
        Stall = 1'b1;
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Big-endian lanes: offset 0 occupies bits [31:24].
  always_comb begin
    shifted  = line >> {~Address[1:0], 3'b000};
    ReadData = '0;
    if (load_hit) begin
      unique case (Size)
        2'b00:   ReadData = {24'b0, shifted[7:0]};
        2'b01:   ReadData = {16'b0, Address[1] ? line[15:0] : line[31:16]};
        default: ReadData = line;
      endcase
    end
  end

  always_comb begin
    unique case (Size)
      2'b00: begin
        st_wdata = {24'b0, WriteData[7:0]} << {~Address[1:0], 3'b000};
        st_be    = 4'b1000 >> Address[1:0];
      end
      2'b01: begin
        st_wdata = Address[1] ? {16'b0, WriteData[15:0]} : {WriteData[15:0], 16'b0};
        st_be    = Address[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        st_wdata = WriteData;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    merged = data_arr[m_idx];
    for (int unsigned i = 0; i < 4; i++)
      if (mem_be[i]) merged[i*8 +: 8] = mem_wdata[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wr_done   <= 1'b0;
    end else begin
      wr_done <= (state == WRITE) && mem_ack;
      if (start_fill || start_write) begin
        mem_req   <= 1'b1;
        mem_we    <= start_write;
        mem_addr  <= {Address[ADDRESS_WIDTH-1:2], 2'b00};
        mem_wdata <= start_write ? st_wdata : '0;
        mem_be    <= start_write ? st_be : 4'hF;
      end else if ((state != IDLE) && mem_ack) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_be    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state == FILL) && mem_ack) valid[m_idx] <= 1'b1;
      if (load_hit && (hit_count != '1))    hit_count  <= hit_count + 1'b1;
      if (start_fill && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == FILL) && mem_ack) begin
      data_arr[m_idx] <= mem_rdata;
      tag_arr[m_idx]  <= m_tag;
    end else if ((state == WRITE) && mem_ack && m_hit) begin
      data_arr[m_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_cache_wt.sv
// Directed bench for data_cache_wt: a 3-cycle memory responder with a word-addressed model,
// and a linear sequence of loads/stores checked against hand-computed values.
module tb_data_cache_wt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Address = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int failures = 0;

  bit [31:0] mem_model [bit [31:0]];
  bit        auto_ack = 1'b1;
  int        lat_cnt = 0;

  logic [31:0] rd, ca, cd, snap;
  logic [3:0]  cb;
  logic        cw;
  int          st, rq;

  data_cache_wt #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SET_WIDTH(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .Size(Size), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Acks on the third cycle of a request; writes update the model through the byte enables.
  always @(negedge clk) begin
    if (!auto_ack) begin
      lat_cnt = 0;
    end else if (rst_n && mem_req && !mem_ack) begin
      lat_cnt++;
      if (lat_cnt == 3) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          bit [31:0] w;
          w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) w[i*8 +: 8] = mem_wdata[i*8 +: 8];
          mem_model[mem_addr] = w;
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end
      end
    end else begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access held until Stall drops; captures the first memory request seen.
  task automatic access(input bit is_store, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
    logic prev;
    @(posedge clk); #1;
    re = !is_store; we = is_store; Address = a; Size = sz; WriteData = wd;
    st = 0; rq = 0; prev = 1'b0;
    ca = '0; cb = '0; cw = 1'b0; cd = '0;
    #1;
    while (Stall && st < 50) begin
      st++;
      @(posedge clk); #1;
      if (mem_req && !prev) begin
        if (rq == 0) begin ca = mem_addr; cb = mem_be; cw = mem_we; cd = mem_wdata; end
        rq++;
      end
      prev = mem_req;
    end
    chk("stall_bound", 32'(st < 50), 32'd1);
    rd = ReadData;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    mem_model[32'h0001_0000] = 32'hDEAD_BEEF;
    mem_model[32'h0001_0100] = 32'hCAFE_F00D;

    #2;
    chk("rst_stall", Stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_miss", miss_count, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: cold miss, then hit
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t1_stall", st, 4);
    chk("t1_data", rd, 32'hDEAD_BEEF);
    chk("t1_miss", miss_count, 32'd1);
    chk("t1_reqs", rq, 1);
    chk("t1_maddr", ca, 32'h0001_0000);
    chk("t1_mbe", {28'b0, cb}, 32'hF);
    chk("t1_mwe", {31'b0, cw}, 32'h0);
    snap = hit_count;
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t1_hit_stall", st, 0);
    chk("t1_hit_data", rd, 32'hDEAD_BEEF);
    chk("t1_hit_cnt", hit_count, snap + 32'd1);
    chk("t1_hit_reqs", rq, 0);

    // 2: sub-word hits
    access(0, 32'h0001_0001, 2'b00, '0);
    chk("t2_byte1", rd, 32'h0000_00AD);
    chk("t2_byte1_stall", st, 0);
    access(0, 32'h0001_0002, 2'b01, '0);
    chk("t2_half2", rd, 32'h0000_BEEF);
    access(0, 32'h0001_0003, 2'b00, '0);
    chk("t2_byte3", rd, 32'h0000_00EF);
    access(0, 32'h0001_0000, 2'b01, '0);
    chk("t2_half0", rd, 32'h0000_DEAD);
    access(0, 32'h0001_0002, 2'b11, '0);
    chk("t2_size11", rd, 32'hDEAD_BEEF);

    // 3: store hits merge into the line
    access(1, 32'h0001_0003, 2'b00, 32'hFFFF_FF5A);
    chk("t3_st_stall", st, 4);
    chk("t3_st_be", {28'b0, cb}, 32'h1);
    chk("t3_st_wdata", cd, 32'h0000_005A);
    chk("t3_st_addr", ca, 32'h0001_0000);
    chk("t3_st_we", {31'b0, cw}, 32'h1);
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t3_reload", rd, 32'hDEAD_BE5A);
    chk("t3_reload_reqs", rq, 0);
    access(1, 32'h0001_0000, 2'b01, 32'h0000_1234);
    chk("t3_sth_be", {28'b0, cb}, 32'hC);
    chk("t3_sth_wdata", cd, 32'h1234_0000);
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t3_reload2", rd, 32'h1234_BE5A);
    chk("t3_mem_model", mem_model[32'h0001_0000], 32'h1234_BE5A);

    // 4: store miss writes memory only
    snap = miss_count;
    access(1, 32'h0001_0400, 2'b10, 32'h1234_5678);
    chk("t4_st_be", {28'b0, cb}, 32'hF);
    chk("t4_st_addr", ca, 32'h0001_0400);
    chk("t4_st_wdata", cd, 32'h1234_5678);
    chk("t4_st_miss", miss_count, snap);
    access(0, 32'h0001_0400, 2'b10, '0);
    chk("t4_ld_stall", st, 4);
    chk("t4_ld_data", rd, 32'h1234_5678);
    chk("t4_ld_miss", miss_count, snap + 32'd1);

    // 5: conflict eviction on index 0
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t5_a_stall", st, 4);
    chk("t5_a_data", rd, 32'h1234_BE5A);
    access(0, 32'h0001_0100, 2'b10, '0);
    chk("t5_b_stall", st, 4);
    chk("t5_b_data", rd, 32'hCAFE_F00D);
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t5_a2_stall", st, 4);
    chk("t5_a2_data", rd, 32'h1234_BE5A);

    // 6: reset mid-fill, then a stray ack
    auto_ack = 1'b0;
    @(posedge clk); #1;
    re = 1'b1; Address = 32'h0001_0400; Size = 2'b10;
    @(posedge clk); #1;
    chk("t6_req_fill", mem_req, 1'b1);
    #2;
    rst_n = 1'b0; re = 1'b0;
    #1;
    chk("t6_req_rst", mem_req, 1'b0);
    chk("t6_stall_rst", Stall, 1'b0);
    chk("t6_miss_rst", miss_count, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    @(posedge clk); #1 mem_ack = 1'b0;
    chk("t6_late_req", mem_req, 1'b0);
    chk("t6_late_stall", Stall, 1'b0);
    chk("t6_late_hits", hit_count, 32'h0);
    auto_ack = 1'b1;
    access(0, 32'h0001_0000, 2'b10, '0);
    chk("t6_reload_stall", st, 4);
    chk("t6_reload_data", rd, 32'h1234_BE5A);
    chk("t6_reload_miss", miss_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
